// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline controller and pipeline registers
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Bubble loaded into a pipeline register on flush: every control bit cleared
    localparam wb_ctrl_t WB_CTRL_NOP = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the sources of ID
module hazard_detect #(
    parameter int REG_ADDR_W = 6
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  load_use
);

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    always_comb begin
        load_use = ex_mem_read && (ex_rd_addr != '0) &&
                   ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                    (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the five-stage pipeline with memory-wait FSM
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = 6,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    pctrl_state_t   state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           mem_err_q;
    logic [CNT_W-1:0] stall_q;
    logic           load_use;
    logic           mem_hold;
    logic           flow;
    logic           branch;
    logic           lu_stall;
    logic           timeout;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd_addr  (ex_rd_addr),
        .load_use    (load_use)
    );

    // Stall/flush decode: memory hold beats branch, branch beats load-use; reset overrides all
    always_comb begin
        mem_hold     = !dmem_ack && ((state_q == RUN && mem_access) || state_q == MEM_WAIT);
        flow         = (state_q != HALT) && !mem_hold;
        branch       = flow && ex_branch_taken;
        lu_stall     = flow && !ex_branch_taken && load_use;
        timeout      = (state_q == MEM_WAIT) && !dmem_ack && (wait_cnt_q == WCW'(MEM_TIMEOUT - 1));
        pc_en        = !rst && flow && !lu_stall;
        if_id_en     = !rst && flow && !lu_stall;
        id_ex_en     = !rst && flow;
        ex_mem_en    = !rst && flow;
        mem_wb_en    = !rst && (state_q != HALT);
        if_id_flush  = rst || branch;
        id_ex_flush  = rst || branch || lu_stall;
        mem_wb_flush = rst || mem_hold;
        dmem_req     = !rst && (state_q != HALT) && mem_access;
        mem_err      = mem_err_q;
        stall_cycles = stall_q;
    end

    // FSM, wait counter, sticky timeout flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            if (!pc_en && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (timeout)
                mem_err_q <= 1'b1;
            case (state_q)
                RUN: begin
                    wait_cnt_q <= '0;
                    state_q    <= (mem_access && !dmem_ack) ? MEM_WAIT : RUN;
                end
                MEM_WAIT: begin
                    wait_cnt_q <= dmem_ack ? '0 : wait_cnt_q + WCW'(1);
                    state_q    <= dmem_ack ? RUN : (timeout ? HALT : MEM_WAIT);
                end
                default: state_q <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a cycle-level reference model
module tb_pipeline_ctrl;

    localparam int AW = 6;
    localparam int T  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_access, dmem_ack;
    logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [CW-1:0] stall_cycles;
    logic [8:0]    ctrl;

    int n_vec = 0;
    int n_err = 0;

    bit       m_wait, m_halt, m_err;
    int       m_cnt;
    logic [CW-1:0] m_stalls;

    always #5 clk = ~clk;

    assign ctrl = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush};

    pipeline_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    // Expected control vector from the priority rules: reset, halt, memory hold, branch, load-use, advance
    function automatic logic [8:0] exp_ctrl();
        logic lu;
        lu = ex_mem_read && ex_rd_addr != 0 &&
             ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        if (rst) return 9'b0_00000_111;
        if (m_halt) return 9'b0;
        if (!dmem_ack && (m_wait || mem_access)) return {mem_access, 8'b00001_001};
        if (ex_branch_taken) return {mem_access, 8'b11111_110};
        if (lu) return {mem_access, 8'b00111_010};
        return {mem_access, 8'b11111_000};
    endfunction

    // Advance one clock and update the model with the inputs held across the edge
    task automatic tick();
        logic [8:0] e;
        e = exp_ctrl();
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0; m_stalls = '0;
        end else begin
            if (!e[7] && m_stalls != '1) m_stalls = m_stalls + 1'b1;
            if (m_halt) begin
            end else if (m_wait) begin
                if (dmem_ack) m_wait = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == T) begin m_halt = 1; m_err = 1; m_wait = 0; end
                end
            end else if (mem_access && !dmem_ack) begin
                m_wait = 1; m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_access = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; #1;
        n_vec++; if (ctrl !== exp_ctrl()) begin n_err++; $display("FAIL reset_ctrl got %b exp %b", ctrl, exp_ctrl()); end
        mem_access = 1; #1;
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", dmem_req); end
        tick(); rst = 0; mem_access = 0; #1;
        n_vec++; if (stall_cycles !== '0 || mem_err !== 1'b0) begin n_err++; $display("FAIL reset_regs got %0d/%b exp 0/0", stall_cycles, mem_err); end
        n_vec++; if (ctrl !== 9'b0_11111_000) begin n_err++; $display("FAIL reset_run got %b exp 011111000", ctrl); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1; #1;
        n_vec++; if (ctrl !== 9'b0_00111_010) begin n_err++; $display("FAIL load_use got %b exp 000111010", ctrl); end
        tick();
        n_vec++; if (stall_cycles !== 8'd1) begin n_err++; $display("FAIL load_use_cnt got %0d exp 1", stall_cycles); end
        ex_rd_addr = 0; id_rs1_addr = 0; #1;
        n_vec++; if (ctrl !== 9'b0_11111_000) begin n_err++; $display("FAIL load_use_x0 got %b exp 011111000", ctrl); end
        ex_rd_addr = 7; id_rs1_addr = 3; id_rs2_addr = 7; id_uses_rs2 = 1; #1;
        n_vec++; if (ctrl !== exp_ctrl()) begin n_err++; $display("FAIL load_use_rs2 got %b exp %b", ctrl, exp_ctrl()); end
        id_uses_rs2 = 0; #1;
        n_vec++; if (ctrl !== exp_ctrl()) begin n_err++; $display("FAIL load_use_unused got %b exp %b", ctrl, exp_ctrl()); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        ex_branch_taken = 1; #1;
        n_vec++; if (ctrl !== 9'b0_11111_110) begin n_err++; $display("FAIL branch got %b exp 011111110", ctrl); end
        tick();
        ex_mem_read = 1; ex_rd_addr = 9; id_rs1_addr = 9; id_uses_rs1 = 1; #1;
        n_vec++; if (ctrl !== 9'b0_11111_110) begin n_err++; $display("FAIL branch_over_lu got %b exp 011111110", ctrl); end
        tick();
        n_vec++; if (stall_cycles !== 8'd0) begin n_err++; $display("FAIL branch_cnt got %0d exp 0", stall_cycles); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1; dmem_ack = 1; #1;
        n_vec++; if (ctrl !== 9'b1_11111_000) begin n_err++; $display("FAIL mem_zero_wait got %b exp 111111000", ctrl); end
        tick(); dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ctrl !== 9'b1_00001_001) begin n_err++; $display("FAIL mem_stall%0d got %b exp 100001001", i, ctrl); end
            tick();
        end
        dmem_ack = 1; #1;
        n_vec++; if (ctrl !== 9'b1_11111_000) begin n_err++; $display("FAIL mem_ack got %b exp 111111000", ctrl); end
        tick(); idle(); #1;
        n_vec++; if (stall_cycles !== 8'd3) begin n_err++; $display("FAIL mem_cnt got %0d exp 3", stall_cycles); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_access = 1;
        for (int i = 0; i < T; i++) tick();
        dmem_ack = 1; #1;
        n_vec++; if (ctrl !== 9'b1_11111_000) begin n_err++; $display("FAIL last_ack got %b exp 111111000", ctrl); end
        tick(); idle(); #1;
        n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL last_ack_err got %b exp 0", mem_err); end
        mem_access = 1;
        for (int i = 0; i < T + 1; i++) tick();
        n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL timeout_err got %b exp 1", mem_err); end
        for (int i = 0; i < 10; i++) begin
            ex_branch_taken = i[0]; #1;
            n_vec++; if (ctrl !== 9'b0 || mem_err !== 1'b1) begin n_err++; $display("FAIL halt%0d got %b/%b exp 000000000/1", i, ctrl, mem_err); end
            tick();
        end
        for (int i = 0; i < 250; i++) tick();
        n_vec++; if (stall_cycles !== 8'hff) begin n_err++; $display("FAIL saturate got %0d exp 255", stall_cycles); end
        do_reset(); #1;
        n_vec++; if (mem_err !== 1'b0 || stall_cycles !== '0) begin n_err++; $display("FAIL halt_clear got %b/%0d exp 0/0", mem_err, stall_cycles); end
    endtask

    task automatic test_branch_in_wait();
        do_reset();
        mem_access = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ctrl !== 9'b1_00001_001) begin n_err++; $display("FAIL br_wait%0d got %b exp 100001001", i, ctrl); end
            tick();
        end
        dmem_ack = 1; #1;
        n_vec++; if (ctrl !== 9'b1_11111_110) begin n_err++; $display("FAIL br_release got %b exp 111111110", ctrl); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        mem_access = 1; tick(); tick();
        rst = 1; #1;
        n_vec++; if (dmem_req !== 1'b0 || ctrl !== 9'b0_00000_111) begin n_err++; $display("FAIL rst_wait got %b exp 000000111", ctrl); end
        tick(); rst = 0; mem_access = 0; #1;
        n_vec++; if (ctrl !== 9'b0_11111_000 || stall_cycles !== '0 || mem_err !== 1'b0) begin n_err++; $display("FAIL rst_wait_after got %b/%0d/%b exp 011111000/0/0", ctrl, stall_cycles, mem_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            ex_mem_read = $urandom_range(0, 1); ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_rd_addr = AW'($urandom_range(0, 3)); id_rs1_addr = AW'($urandom_range(0, 3)); id_rs2_addr = AW'($urandom_range(0, 3));
            id_uses_rs1 = $urandom_range(0, 1); id_uses_rs2 = $urandom_range(0, 1);
            mem_access = ($urandom_range(0, 2) == 0); dmem_ack = ($urandom_range(0, 2) != 0);
            #1;
            n_vec++; if (ctrl !== exp_ctrl()) begin n_err++; $display("FAIL rand_ctrl[%0d] got %b exp %b", i, ctrl, exp_ctrl()); end
            tick();
            n_vec++; if (stall_cycles !== m_stalls || mem_err !== m_err) begin n_err++; $display("FAIL rand_regs[%0d] got %0d/%b exp %0d/%b", i, stall_cycles, mem_err, m_stalls, m_err); end
        end
    endtask

    initial begin
        m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0; m_stalls = '0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_branch_in_wait();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses over a req/ack handshake. Counts stall cycles and latches a sticky error on memory timeout.

## Interface
- `REG_ADDR_W`, default 6: width of register-address fields. Matches the `rd` fields of the pipeline registers.
- `MEM_TIMEOUT`, default 255: maximum number of MEM_WAIT cycles before HALT. Must be ≥1.
- `CNT_W`, default 32: width of the stall-cycle counter.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `id_rs1_addr`, `id_rs2_addr`  in  REG_ADDR_W  source registers of the instruction in ID
- `id_uses_rs1`, `id_uses_rs2`  in  1  instruction in ID reads that source
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_rd_addr`  in  REG_ADDR_W  destination register of the instruction in EX
- `ex_branch_taken`  in  1  instruction in EX resolved as a taken branch or jump
- `mem_access`  in  1  instruction in MEM is a load or store
- `dmem_ack`  in  1  data memory completes the access this cycle
- `dmem_req`  out  1  data memory request
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  register load enables
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1  load a bubble (all control bits zero)
- `mem_err`  out  1  sticky memory-timeout flag
- `stall_cycles`  out  CNT_W  saturating count of cycles with `pc_en`=0

## Operation
- FSM states:
  - RUN (reset state)
  - MEM_WAIT
  - HALT
- In RUN, the pipeline advances by default: all enables are 1 and all flushes are 0.
- `dmem_req` = `mem_access` in RUN and MEM_WAIT; 0 in HALT.
- Memory stall (highest priority):
  - In RUN, if `mem_access`=1 and `dmem_ack`=0, then `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` are 0.
  - `mem_wb_en`=1 with `mem_wb_flush`=1, so the MEM/WB register captures a bubble.
  - Next state is MEM_WAIT and `wait_cnt` clears to 0.
- MEM_WAIT:
  - Outputs are identical to the memory-stall case above.
  - On `dmem_ack`=1: normal advance this cycle (all enables 1, `mem_wb_flush`=0), then go to RUN.
  - Otherwise, `wait_cnt` increments. When `wait_cnt` = MEM_TIMEOUT−1 with no ack, go to HALT.
- HALT:
  - All enables are 0, all flushes are 0, `dmem_req`=0.
  - `mem_err`=1 until `rst`.
- Taken branch (RUN, no memory stall):
  - `if_id_flush`=1 and `id_ex_flush`=1.
  - `pc_en`=1; the target is selected outside this block.
  - Branch takes priority over load-use.
- Load-use hazard (RUN, no memory stall, no branch):
  - Condition: `ex_mem_read`=1, `ex_rd_addr`≠0, and it matches a used rs (`id_uses_rsN`=1 and `id_rsN_addr`=`ex_rd_addr`).
  - Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1. `ex_mem_en` and `mem_wb_en` stay 1.
  - The hazard lasts one cycle by construction.
- A branch that coincides with a memory stall is held in EX (frozen). Its flush is issued on the cycle the stall releases.
- `stall_cycles` increments in every non-reset cycle with `pc_en`=0 and saturates at all-ones.
- Reset, while `rst`=1:
  - All enables 0; `if_id_flush`, `id_ex_flush`, `mem_wb_flush` = 1; `dmem_req`=0.
  - Next state is RUN; `wait_cnt`, `stall_cycles` and `mem_err` clear to 0.
  - Reset mid-MEM_WAIT abandons the access; `dmem_req` drops in the same cycle.

## Timing
- Enables, flushes and `dmem_req` are combinational from state and inputs; they take effect at the next `clk` edge.
- `mem_err` and `stall_cycles` are registered and update one cycle after the causing condition.
- Zero-wait memory (ack in the request cycle): no stall.
- Each cycle of ack delay costs one stall cycle.
- Timeout: 1 RUN request cycle plus MEM_TIMEOUT MEM_WAIT cycles without ack. `mem_err`=1 on the following cycle.
- An ack on the final MEM_WAIT cycle is accepted and no error is raised.

## Structure
- Shared `pipeline_pkg` contains:
  - `pctrl_state_t` (RUN, MEM_WAIT, HALT).
  - The bubble constant `WB_CTRL_NOP` (all zeros), shared with the pipeline registers.
- Sub-module `hazard_detect`: combinational load-use compare. Inputs are the rs/rd/use/load signals; output is `load_use`.
- FSM, `wait_cnt` (width $clog2(MEM_TIMEOUT+1)) and the stall counter live in `pipeline_ctrl`.

## Test plan
- Load x5 in EX, ID reads rs1=x5 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_cycles`=1. Repeat with `ex_rd_addr`=0 → no stall.
- `ex_branch_taken`=1 → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, `stall_cycles` unchanged. Same cycle with a load-use match → branch response only.
- `mem_access`=1, ack after 3 cycles → 3 cycles with the front four enables 0 and `mem_wb_flush`=1, then one advance cycle; `stall_cycles`=3.
- MEM_TIMEOUT=4, no ack → 1 RUN + 4 MEM_WAIT cycles, then HALT: `mem_err`=1, `dmem_req`=0, all enables 0. Still held after 10 more cycles; cleared only by `rst`.
- Branch taken during a 2-cycle memory wait → no flush while stalled; flush asserted on the ack cycle.
- `rst` asserted during MEM_WAIT → `dmem_req`=0 that cycle; after release, state is RUN, `stall_cycles`=0, `mem_err`=0.
